// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the fetch PC, runs a single-outstanding ibus request/response
// handshake and applies branch (delayed) and exception (immediate) redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        StallF,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    input  logic        branchD,
    output logic [31:0] instrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        BDF,
    output logic [7:0]  EVectorF,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop;       // response of an abandoned request still due
    logic        r_hold;       // abandoned request still waiting for addr_ok
    logic [31:0] r_hold_addr;  // address of that abandoned request
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;
    logic [31:0] r_ibuf;

    state_t      w_state_n;
    logic [31:0] w_pc_n;
    logic        w_drop_n;
    logic        w_hold_n;
    logic [31:0] w_hold_addr_n;
    logic        w_pend_valid_n;
    logic [31:0] w_pend_pc_n;
    logic        w_cap;

    logic        w_mis;
    logic        w_mis_done;
    logic        w_done;
    logic        w_accept;

    // A misaligned PC completes at once (AdEL) unless an old request is pending.
    assign w_mis      = (r_pc[1:0] != 2'b00);
    assign w_mis_done = (r_state == S_REQ) && !r_hold && w_mis;
    assign w_done     = (r_state == S_DONE) || w_mis_done;
    assign w_accept   = w_done && !StallF && !exc_valid;

    assign ireq_valid = !reset && (r_state == S_REQ) && (r_hold || !w_mis);
    assign ireq_addr  = r_hold ? r_hold_addr : r_pc;
    assign instrF     = (!reset && (r_state == S_DONE)) ? r_ibuf : 32'd0;
    assign EVectorF   = {7'd0, (!reset && w_mis_done)};
    assign fetch_busy = !w_done || r_drop;
    assign PCF        = r_pc;
    assign PCPlus4F   = r_pc + 32'd4;
    assign BDF        = branchD;

    // Next-state logic: bus handshake FSM, then PC / pending-branch update.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_drop_n       = r_drop;
        w_hold_n       = r_hold;
        w_hold_addr_n  = r_hold_addr;
        w_pend_valid_n = r_pend_valid;
        w_pend_pc_n    = r_pend_pc;
        w_cap          = 1'b0;

        case (r_state)
            S_REQ: begin
                if (r_hold) begin
                    // Finish the abandoned request; its data is never kept.
                    if (iresp_addr_ok) begin
                        w_hold_n = 1'b0;
                        if (!iresp_data_ok) begin
                            w_drop_n  = 1'b1;
                            w_state_n = S_WAIT;
                        end
                    end
                end else if (!w_mis) begin
                    if (iresp_addr_ok) begin
                        if (iresp_data_ok) begin
                            if (!exc_valid) begin
                                w_cap     = 1'b1;
                                w_state_n = S_DONE;
                            end
                        end else begin
                            w_state_n = S_WAIT;
                            if (exc_valid) w_drop_n = 1'b1;
                        end
                    end else if (exc_valid) begin
                        w_hold_n      = 1'b1;
                        w_hold_addr_n = r_pc;
                    end
                end
            end
            S_WAIT: begin
                if (iresp_data_ok) begin
                    if (r_drop || exc_valid) begin
                        w_drop_n  = 1'b0;
                        w_state_n = S_REQ;
                    end else begin
                        w_cap     = 1'b1;
                        w_state_n = S_DONE;
                    end
                end else if (exc_valid) begin
                    w_drop_n = 1'b1;
                end
            end
            S_DONE: begin
                if (exc_valid || !StallF) w_state_n = S_REQ;
            end
            default: w_state_n = S_REQ;
        endcase

        if (exc_valid) begin
            w_pc_n         = exc_pc;
            w_pend_valid_n = 1'b0;
        end else if (w_accept) begin
            if (r_pend_valid) begin
                w_pc_n         = r_pend_pc;
                w_pend_valid_n = redirect_valid;
                if (redirect_valid) w_pend_pc_n = redirect_pc;
            end else if (redirect_valid) begin
                // The word being accepted is the delay slot: jump straight away.
                w_pc_n = redirect_pc;
            end else begin
                w_pc_n = r_pc + 32'd4;
            end
        end else if (redirect_valid) begin
            w_pend_valid_n = 1'b1;
            w_pend_pc_n    = redirect_pc;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_hold       <= 1'b0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_drop       <= w_drop_n;
            r_hold       <= w_hold_n;
            r_pend_valid <= w_pend_valid_n;
        end
    end

    // Data-side registers; only meaningful while their qualifying flag is set.
    always_ff @(posedge clk) begin
        if (w_cap) r_ibuf <= iresp_data;
        r_hold_addr <= w_hold_addr_n;
        r_pend_pc   <= w_pend_pc_n;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized phase for fetch_stage,
// with an ibus responder and a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset, ireq_valid, iresp_addr_ok, iresp_data_ok;
    logic        StallF, redirect_valid, exc_valid, branchD, BDF, fetch_busy;
    logic [31:0] ireq_addr, iresp_data, redirect_pc, exc_pc, instrF, PCF, PCPlus4F;
    logic [7:0]  EVectorF;

    int checks = 0;
    int errors = 0;

    // ibus responder knobs and state
    int          aok_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    int          lat;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    bit          rb_busy = 1'b0;
    int          rb_cnt;
    logic [31:0] rb_addr;
    logic [31:0] q_acc[$];

    // reference model: architectural fetch PC, delayed branch target,
    // captured word, a held abandoned request and an in-flight response
    logic [31:0] m_pc = RPC;
    bit          m_pend_v = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    bit          m_avail = 1'b0;
    logic [31:0] m_word = 32'h0;
    bit          m_req_v = 1'b0;
    logic [31:0] m_req_addr = 32'h0;
    bit          m_if_v = 1'b0;
    logic [31:0] m_if_addr = 32'h0;
    bit          m_if_stale = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .StallF(StallF), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .branchD(branchD),
        .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .BDF(BDF),
        .EVectorF(EVectorF), .fetch_busy(fetch_busy)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a ^ 32'h5A5A_A5A5) + {a[7:0], a[31:8]} + 32'h0000_0101;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return ovr_en ? ovr_data : mem(a);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, respond on the bus, check against the model,
    // advance the model, then cross the edge.
    task automatic step(input bit rst_i, input bit st_i, input bit rv_i, input logic [31:0] rpc_i,
                        input bit ev_i, input logic [31:0] epc_i, input bit bd_i);
        bit          pres, done, stl, accept;
        logic [31:0] paddr;
        reset = rst_i; StallF = st_i; redirect_valid = rv_i; redirect_pc = rpc_i;
        exc_valid = ev_i; exc_pc = epc_i; branchD = bd_i;
        #1;
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'h0;
        if (!rst_i) begin
            if (rb_busy) begin
                if (rb_cnt == 1) begin
                    iresp_data_ok = 1'b1;
                    iresp_data = rd(rb_addr);
                end
            end else if (ireq_valid === 1'b1 && int'($urandom_range(99)) < aok_pct) begin
                iresp_addr_ok = 1'b1;
                lat = int'($urandom_range(lat_max, lat_min));
                if (lat == 0) begin
                    iresp_data_ok = 1'b1;
                    iresp_data = rd(ireq_addr);
                end
            end
            if (ireq_valid === 1'b1 && iresp_addr_ok) q_acc.push_back(ireq_addr);
        end
        #3;
        pres  = m_req_v || (!m_if_v && !m_avail && m_pc[1:0] == 2'b00);
        paddr = m_req_v ? m_req_addr : m_pc;
        done  = m_avail || (m_pc[1:0] != 2'b00 && !m_req_v && !m_if_v);
        if (rst_i) begin
            chk1("rst_ireq_valid", ireq_valid, 1'b0);
            chk32("rst_instrF", instrF, 32'h0);
            chk32("rst_EVectorF", 32'(EVectorF), 32'h0);
        end else begin
            chk1("ireq_valid", ireq_valid, pres);
            if (pres) chk32("ireq_addr", ireq_addr, paddr);
            chk32("PCF", PCF, m_pc);
            chk32("PCPlus4F", PCPlus4F, m_pc + 32'd4);
            chk1("fetch_busy", fetch_busy, !done);
            chk32("instrF", instrF, (done && m_pc[1:0] == 2'b00) ? m_word : 32'h0);
            chk32("EVectorF", 32'(EVectorF), (done && m_pc[1:0] != 2'b00) ? 32'h1 : 32'h0);
            chk1("BDF", BDF, bd_i);
        end
        if (rst_i) begin
            m_pc = RPC; m_pend_v = 1'b0; m_avail = 1'b0; m_req_v = 1'b0; m_if_v = 1'b0;
            rb_busy = 1'b0;
        end else begin
            // bus side: a request made stale by an exception still completes
            if (pres && iresp_addr_ok) begin
                stl = m_req_v || ev_i;
                m_req_v = 1'b0;
                if (iresp_data_ok) begin
                    if (!stl) begin m_avail = 1'b1; m_word = mem(paddr); end
                end else begin
                    m_if_v = 1'b1; m_if_addr = paddr; m_if_stale = stl;
                end
            end else if (pres && ev_i) begin
                m_req_v = 1'b1; m_req_addr = paddr;
            end else if (m_if_v && iresp_data_ok) begin
                if (!(m_if_stale || ev_i)) begin m_avail = 1'b1; m_word = mem(m_if_addr); end
                m_if_v = 1'b0;
            end else if (m_if_v && ev_i) begin
                m_if_stale = 1'b1;
            end
            // program flow: delayed branches, immediate exceptions
            accept = done && !st_i && !ev_i;
            if (ev_i) begin
                m_pc = epc_i; m_pend_v = 1'b0; m_avail = 1'b0;
            end else if (accept) begin
                m_avail = 1'b0;
                if (m_pend_v) begin
                    m_pc = m_pend_pc; m_pend_v = rv_i;
                    if (rv_i) m_pend_pc = rpc_i;
                end else if (rv_i) begin
                    m_pc = rpc_i;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end else if (rv_i) begin
                m_pend_v = 1'b1; m_pend_pc = rpc_i;
            end
            // responder bookkeeping
            if (rb_busy) begin
                if (rb_cnt == 1) rb_busy = 1'b0;
                else rb_cnt--;
            end else if (iresp_addr_ok && !iresp_data_ok) begin
                rb_busy = 1'b1; rb_cnt = lat; rb_addr = ireq_addr;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit bd_i);
        for (int i = 0; i < 20; i++) begin
            if (fetch_busy === 1'b0) break;
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, bd_i);
        end
        chk1("wait_idle_timeout", fetch_busy, 1'b0);
    endtask

    initial begin
        logic [31:0] pc_hold, rpc, epc;
        bit          rr, st, rv, ev, bd;

        reset = 1'b1; StallF = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        exc_valid = 1'b0; exc_pc = 32'h0; branchD = 1'b0;
        iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'h0;

        // reset state
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk32("reset_PCF", PCF, RPC);
        chk32("reset_PCPlus4F", PCPlus4F, RPC + 32'd4);

        // zero-latency bus: one instruction every two cycles
        q_acc.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk32("seq_count", 32'(q_acc.size()), 32'd3);
        chk32("seq_addr0", (q_acc.size() > 0) ? q_acc[0] : 32'h0, 32'hBFC0_0000);
        chk32("seq_addr1", (q_acc.size() > 1) ? q_acc[1] : 32'h0, 32'hBFC0_0004);
        chk32("seq_addr2", (q_acc.size() > 2) ? q_acc[2] : 32'h0, 32'hBFC0_0008);

        // StallF held for three cycles in DONE
        wait_idle(1'b0);
        pc_hold = PCF;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk32("stall_PCF", PCF, pc_hold);
            chk1("stall_ireq_valid", ireq_valid, 1'b0);
            chk32("stall_instrF", instrF, mem(pc_hold));
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk32("stall_release_PCF", PCF, pc_hold + 32'd4);

        // branch at 80000000, delay slot 80000004, target 80001000
        wait_idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
        wait_idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, 32'h0, 1'b1);
        wait_idle(1'b1);
        chk32("bd_slot_PCF", PCF, 32'h8000_0004);
        chk32("bd_slot_instrF", instrF, mem(32'h8000_0004));
        chk1("bd_slot_BDF", BDF, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk32("bd_target_PCF", PCF, 32'h8000_1000);
        chk1("bd_target_valid", ireq_valid, 1'b1);
        chk32("bd_target_addr", ireq_addr, 32'h8000_1000);

        // exception while waiting for data: the late response is dropped
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b0);
        chk1("drop_no_deadbeef0", instrF === 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk1("drop_no_deadbeef1", instrF === 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk1("drop_no_deadbeef2", instrF === 32'hDEAD_BEEF, 1'b0);
        ovr_en = 1'b0; lat_min = 0; lat_max = 0;
        chk1("drop_next_valid", ireq_valid, 1'b1);
        chk32("drop_next_addr", ireq_addr, 32'hBFC0_0380);
        wait_idle(1'b0);
        chk32("drop_next_instrF", instrF, mem(32'hBFC0_0380));

        // misaligned exception target: AdEL without any bus request
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0002, 1'b0);
        chk1("adel_ireq_valid", ireq_valid, 1'b0);
        chk32("adel_instrF", instrF, 32'h0);
        chk32("adel_EVectorF", 32'(EVectorF), 32'h1);
        chk1("adel_fetch_busy", fetch_busy, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b0);

        // reset while a response is outstanding
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk1("wait_busy", fetch_busy, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk32("rst_wait_PCF", PCF, RPC);
        chk1("rst_wait_ireq_valid", ireq_valid, 1'b0);
        lat_min = 0; lat_max = 0;
        q_acc.delete();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk32("rst_first_addr", (q_acc.size() > 0) ? q_acc[0] : 32'h0, RPC);

        // randomized traffic against the model
        aok_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            rr  = ($urandom_range(199) == 0);
            st  = ($urandom_range(99) < 25);
            rv  = ($urandom_range(99) < 8);
            ev  = ($urandom_range(99) < 3);
            bd  = $urandom_range(1) == 1;
            rpc = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(15) == 0) ? 32'd2 : 32'd0);
            epc = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(7) == 0) ? 32'd1 : 32'd0);
            step(rr, st, rv, rpc, ev, epc, bd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
